decodificador_bcd_a_decimal: RTL and testbench
==============================================

DECODIFICADOR_BCD_A_DECIMAL -- requirements
Module: decodificador_bcd_a_decimal

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port list SHALL be as follows.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_bcd  input  4  BCD code, natural binary 0..9; 10..15 invalid.
- in_valid  input  1  in_bcd is valid this cycle.
- in_ready  output  1  block can accept a code this cycle.
- out_dec  output  10  decoded 1-of-10 digit; bit k high means digit k.
- out_err  output  1  head entry came from an invalid code (10..15).
- out_valid  output  1  out_dec/out_err hold a valid entry.
- out_ready  input  1  consumer takes the head entry this cycle.
- clr_err  input  1  synchronous clear of err_cnt.
- err_cnt  output  8  saturating count of accepted invalid codes.
- level  output  2  buffer occupancy: 0, 1 or 2.

Function
REQ-003 Push SHALL occur on a cycle with in_valid=1 and in_ready=1; pop SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-004 At push, each code SHALL be decoded and stored as {err, one-hot[9:0]}.
- Codes 0..9: exactly bit in_bcd set, err=0.
- Codes 10..15: one-hot all zero, err=1.
REQ-005 Storage SHALL be a 2-entry FIFO of decoded entries. Order SHALL be preserved.
REQ-006 out_dec and out_err SHALL be driven directly from the head register, with no combinational path from in_bcd.
REQ-007 When out_valid=0, out_dec SHALL be 10'b0 and out_err SHALL be 0.
REQ-008 FSM states SHALL be EMPTY, ONE and FULL. level SHALL be 0, 1 or 2 respectively.
REQ-009 in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL. It SHALL NOT depend combinationally on out_ready.
REQ-010 out_valid SHALL be 1 in ONE and FULL.
REQ-011 Transitions SHALL be as follows.
- EMPTY + push -> ONE.
- ONE + push only -> FULL.
- ONE + pop only -> EMPTY.
- ONE + push and pop in the same cycle -> ONE, with the new entry becoming head on the next cycle.
- FULL + pop -> ONE, with the second entry becoming head.
- All other cases hold state.
REQ-012 Latency SHALL be 1 cycle: a code pushed at edge N into EMPTY SHALL be presented with out_valid=1 after edge N.
REQ-013 Sustained throughput SHALL be one entry per cycle when out_ready is held at 1.
REQ-014 err_cnt SHALL increment by 1 on every push of an invalid code and SHALL saturate at 255.
REQ-015 clr_err=1 SHALL set err_cnt to 0 on the next edge. clr_err SHALL take priority over a simultaneous increment.
REQ-016 Head entry and out_valid SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-017 On rst_n low, the block SHALL immediately set:
- state EMPTY, level 0;
- out_valid 0, out_dec 10'b0, out_err 0;
- err_cnt 0;
- both FIFO entries 0.
REQ-018 in_ready SHALL be 0 while rst_n is low, and 1 from the first cycle after rst_n rises.
REQ-019 Reset asserted mid-operation SHALL discard all buffered entries. No partial entry SHALL appear after release.

Structure
REQ-020 A shared package SHALL hold:
- constants N_DIGITS=10, BCD_W=4, ERR_CNT_W=8, DEPTH=2;
- the FSM state enumeration.
REQ-021 The pure combinational decode (code -> {err, one-hot}) SHALL be a sub-module named bcd_a_uno_de_diez, instantiated once at the FIFO input.

Verification
REQ-022 Reset then sweep in_bcd 0..9, one per cycle, with out_ready=1 -> out_dec = 10'b1 shifted left by k, one cycle later each; out_err=0; err_cnt=0.
REQ-023 Push 12, then 15, then 3 -> entries out_dec=0/out_err=1, out_dec=0/out_err=1, then out_dec=10'b0000001000/out_err=0; err_cnt=2.
REQ-024 out_ready=0, push 5, 7, then 9 -> after two pushes level=2 and in_ready=0; 9 is not accepted. Then out_ready=1 -> outputs 5, then 7, in order.
REQ-025 Level=1 with head 4; push 6 and pop in the same cycle -> level stays 1 and next head is 6 (out_dec=10'b0001000000).
REQ-026 Push 300 invalid codes -> err_cnt=255. Then clr_err together with an invalid push -> err_cnt=0.
REQ-027 Level=2, assert rst_n low for one cycle mid-stream -> out_valid=0, level=0, err_cnt=0 immediately. First push after release appears with 1-cycle latency.

Source files
------------

// File: rtl/decodificador_bcd_a_decimal_pkg.sv
// Shared definitions for the BCD to 1-of-10 decoder with its 2-entry output FIFO.
//   N_DIGITS  : width of the one-hot digit field
//   BCD_W     : width of the incoming BCD code
//   ERR_CNT_W : width of the saturating invalid-code counter
//   DEPTH     : number of decoded entries buffered
//   state_e   : occupancy FSM (empty / one entry / full)
//   entry_t   : one stored decoded entry {err, one-hot}
package decodificador_bcd_a_decimal_pkg;

  localparam int unsigned N_DIGITS  = 10;
  localparam int unsigned BCD_W     = 4;
  localparam int unsigned ERR_CNT_W = 8;
  localparam int unsigned DEPTH     = 2;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  typedef struct packed {
    logic                err;
    logic [N_DIGITS-1:0] dec;
  } entry_t;

endpackage

// File: rtl/decodificador_bcd_a_decimal_uno_de_diez.sv
// Pure combinational decode of a BCD code into a 1-of-10 digit plus an error flag.
//   code_i : BCD code, 0..9 valid, 10..15 invalid
//   dec_o  : one-hot digit, all zero for invalid codes
//   err_o  : high when code_i is 10..15
module bcd_a_uno_de_diez
  import decodificador_bcd_a_decimal_pkg::*;
(
  input  logic [BCD_W-1:0]    code_i,
  output logic [N_DIGITS-1:0] dec_o,
  output logic                err_o
);

  always_comb begin
    dec_o = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      dec_o[k] = (code_i == BCD_W'(k));
    end
    err_o = (code_i > BCD_W'(N_DIGITS - 1));
  end

endmodule

// File: rtl/decodificador_bcd_a_decimal.sv
// BCD to decimal decoder with a 2-entry ready/valid output FIFO and an invalid-code counter.
//   clk, rst_n          : clock and asynchronous active-low reset
//   in_bcd/in_valid     : input code handshake; in_ready low when the FIFO is full
//   out_dec/out_err     : head entry, driven straight from the head register
//   out_valid/out_ready : output handshake
//   clr_err             : synchronous clear of err_cnt (wins over increment)
//   err_cnt             : saturating count of accepted invalid codes
//   level               : occupancy 0, 1 or 2
module decodificador_bcd_a_decimal
  import decodificador_bcd_a_decimal_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BCD_W-1:0]     in_bcd,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N_DIGITS-1:0]  out_dec,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 clr_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           level
);

  state_e                state_q, state_d;
  entry_t                head_q, head_d;
  entry_t                tail_q, tail_d;
  logic [ERR_CNT_W-1:0]  cnt_q, cnt_d;
  entry_t                new_entry;
  logic                  push, pop;

  bcd_a_uno_de_diez u_decode (
    .code_i (in_bcd),
    .dec_o  (new_entry.dec),
    .err_o  (new_entry.err)
  );

  // Gating with rst_n keeps in_ready low for the whole reset window; no out_ready path.
  assign in_ready  = rst_n & (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // The head register is cleared whenever it empties, so it can drive outputs directly.
  assign out_dec = head_q.dec;
  assign out_err = head_q.err;
  assign err_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          head_d  = new_entry;
          state_d = StOne;
        end
      end
      StOne: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          state_d = StFull;
        end else if (pop) begin
          head_d  = '0;
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          head_d  = tail_q;
          tail_d  = '0;
          state_d = StOne;
        end
      end
      default: begin
        state_d = StEmpty;
        head_d  = '0;
        tail_d  = '0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_err) begin
      cnt_d = '0;
    end else if (push && new_entry.err && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    level = 2'd0;
    unique case (state_q)
      StOne:   level = 2'd1;
      StFull:  level = 2'd2;
      default: level = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_decodificador_bcd_a_decimal.sv
module tb_decodificador_bcd_a_decimal;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_bcd;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] out_dec;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;
  logic       clr_err;
  logic [7:0] err_cnt;
  logic [1:0] level;

  int n_cmp;
  int n_fail;

  decodificador_bcd_a_decimal dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bcd    (in_bcd),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_dec   (out_dec),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clr_err   (clr_err),
    .err_cnt   (err_cnt),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_bcd = 4'd0; in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    tick();
    tick();
    n_cmp++; if (level !== 2'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_dec !== 10'b0) begin n_fail++; $display("FAIL reset_out_dec got %b want 0", out_dec); end
    n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err got %b want 0", out_err); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_sweep();
    logic [9:0] exp;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_bcd = 4'(k);
      tick();
      exp = 10'd1 << k;
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sweep_valid[%0d] got %b want 1", k, out_valid); end
      n_cmp++; if (out_dec !== exp) begin n_fail++; $display("FAIL sweep_dec[%0d] got %b want %b", k, out_dec, exp); end
      n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL sweep_err[%0d] got %b want 0", k, out_err); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (level !== 2'd0) begin n_fail++; $display("FAIL sweep_drain_level got %0d want 0", level); end
    n_cmp++; if (out_dec !== 10'b0) begin n_fail++; $display("FAIL sweep_idle_dec got %b want 0", out_dec); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL sweep_err_cnt got %0d want 0", err_cnt); end
  endtask

  task automatic test_invalid();
    logic [3:0] codes [3];
    logic [9:0] exp_dec [3];
    logic       exp_err [3];
    codes = '{4'd12, 4'd15, 4'd3};
    exp_dec = '{10'b0, 10'b0, 10'b0000001000};
    exp_err = '{1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_bcd = codes[i];
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL inv_valid[%0d] got %b want 1", i, out_valid); end
      n_cmp++; if (out_dec !== exp_dec[i]) begin n_fail++; $display("FAIL inv_dec[%0d] got %b want %b", i, out_dec, exp_dec[i]); end
      n_cmp++; if (out_err !== exp_err[i]) begin n_fail++; $display("FAIL inv_err[%0d] got %b want %b", i, out_err, exp_err[i]); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL inv_err_cnt got %0d want 2", err_cnt); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inv_drain_valid got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_bcd = 4'd5;
    tick();
    n_cmp++; if (level !== 2'd1) begin n_fail++; $display("FAIL bp_level1 got %0d want 1", level); end
    in_bcd = 4'd7;
    tick();
    n_cmp++; if (level !== 2'd2) begin n_fail++; $display("FAIL bp_level2 got %0d want 2", level); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    in_bcd = 4'd9;
    tick();
    n_cmp++; if (level !== 2'd2) begin n_fail++; $display("FAIL bp_level_hold got %0d want 2", level); end
    n_cmp++; if (out_dec !== 10'b0000100000) begin n_fail++; $display("FAIL bp_head_stable got %b want 0000100000", out_dec); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_stable got %b want 1", out_valid); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_cmp++; if (out_dec !== 10'b0010000000) begin n_fail++; $display("FAIL bp_second got %b want 0010000000", out_dec); end
    n_cmp++; if (level !== 2'd1) begin n_fail++; $display("FAIL bp_level_after_pop got %0d want 1", level); end
    tick();
    n_cmp++; if (level !== 2'd0) begin n_fail++; $display("FAIL bp_drained got %0d want 0 (9 must not be stored)", level); end
  endtask

  task automatic test_push_pop_same();
    out_ready = 1'b0;
    in_valid = 1'b1; in_bcd = 4'd4;
    tick();
    n_cmp++; if (out_dec !== 10'b0000010000) begin n_fail++; $display("FAIL pp_head4 got %b want 0000010000", out_dec); end
    in_bcd = 4'd6; out_ready = 1'b1;
    tick();
    n_cmp++; if (level !== 2'd1) begin n_fail++; $display("FAIL pp_level got %0d want 1", level); end
    n_cmp++; if (out_dec !== 10'b0001000000) begin n_fail++; $display("FAIL pp_head6 got %b want 0001000000", out_dec); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (level !== 2'd0) begin n_fail++; $display("FAIL pp_drain got %0d want 0", level); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    in_valid = 1'b1; in_bcd = 4'd13;
    for (int i = 0; i < 300; i++) tick();
    n_cmp++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_err_cnt got %0d want 255", err_cnt); end
    in_bcd = 4'd14; clr_err = 1'b1;
    tick();
    n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_priority got %0d want 0", err_cnt); end
    clr_err = 1'b0; in_valid = 1'b0;
    tick();
    n_cmp++; if (level !== 2'd0) begin n_fail++; $display("FAIL sat_drain got %0d want 0", level); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_bcd = 4'd1;
    tick();
    in_bcd = 4'd10;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (level !== 2'd2) begin n_fail++; $display("FAIL mr_pre_level got %0d want 2", level); end
    n_cmp++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL mr_pre_err_cnt got %0d want 1", err_cnt); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_out_valid got %b want 0", out_valid); end
    n_cmp++; if (level !== 2'd0) begin n_fail++; $display("FAIL mr_level got %0d want 0", level); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL mr_err_cnt got %0d want 0", err_cnt); end
    n_cmp++; if (out_dec !== 10'b0) begin n_fail++; $display("FAIL mr_out_dec got %b want 0", out_dec); end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_release_valid got %b want 0", out_valid); end
    out_ready = 1'b1; in_valid = 1'b1; in_bcd = 4'd8;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mr_first_valid got %b want 1", out_valid); end
    n_cmp++; if (out_dec !== 10'b0100000000) begin n_fail++; $display("FAIL mr_first_dec got %b want 0100000000", out_dec); end
    tick();
    n_cmp++; if (level !== 2'd0) begin n_fail++; $display("FAIL mr_tail_gone got %0d want 0", level); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_sweep();
    test_invalid();
    test_backpressure();
    test_push_pop_same();
    test_saturation();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
